// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - LC-3 memory responder: strobe episodes to timed SRAM or switch/hex I/O accesses
module lc3_mem_responder #(
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned WR_PULSE = 2,
  parameter logic [15:0] IO_ADDR  = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic [15:0] MAR,
  input  logic [15:0] MDR_out,
  input  logic [15:0] Switches,
  input  logic [15:0] SRAM_DQ_in,
  output logic [15:0] Data_to_CPU,
  output logic [15:0] HEX_Data,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WR_SETUP,
    S_WR_PULSE,
    S_DONE
  } state_t;

  localparam logic [1:0] RD_LAST = 2'(RD_LAT - 1);
  localparam logic [1:0] WR_LAST = 2'(WR_PULSE - 1);

  state_t     r_state;
  logic [1:0] r_cnt;
  logic       r_ce_n;
  logic       w_strobe;
  logic       w_io;

  assign w_strobe  = Mem_OE | Mem_WE;
  assign w_io      = (MAR == IO_ADDR);
  assign SRAM_CE_N = r_ce_n;
  assign SRAM_UB_N = r_ce_n;
  assign SRAM_LB_N = r_ce_n;
  assign Busy      = (r_state != S_IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 2'd0;
      r_ce_n      <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      SRAM_DQ_oe  <= 1'b0;
      SRAM_ADDR   <= 20'd0;
      SRAM_DQ_out <= 16'd0;
      Data_to_CPU <= 16'd0;
      HEX_Data    <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Write wins because the controller also raises Mem_OE during writes
          if (Mem_WE) begin
            if (w_io) begin
              HEX_Data <= MDR_out;
              r_state  <= S_DONE;
            end else begin
              SRAM_ADDR   <= {4'b0, MAR};
              SRAM_DQ_out <= MDR_out;
              r_ce_n      <= 1'b0;
              SRAM_DQ_oe  <= 1'b1;
              r_state     <= S_WR_SETUP;
            end
          end else if (Mem_OE) begin
            if (w_io) begin
              Data_to_CPU <= Switches;
              r_state     <= S_DONE;
            end else begin
              SRAM_ADDR <= {4'b0, MAR};
              r_ce_n    <= 1'b0;
              SRAM_OE_N <= 1'b0;
              r_cnt     <= 2'd0;
              r_state   <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (!w_strobe) begin
            r_ce_n    <= 1'b1;
            SRAM_OE_N <= 1'b1;
            r_state   <= S_IDLE;
          end else if (r_cnt == RD_LAST) begin
            Data_to_CPU <= SRAM_DQ_in;
            r_ce_n      <= 1'b1;
            SRAM_OE_N   <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_WR_SETUP: begin
          SRAM_WE_N <= 1'b0;
          r_cnt     <= 2'd0;
          r_state   <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          // A started write always runs its full pulse, strobe or not
          if (r_cnt == WR_LAST) begin
            SRAM_WE_N  <= 1'b1;
            SRAM_DQ_oe <= 1'b0;
            r_ce_n     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_DONE: begin
          if (!w_strobe) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb/tb_lc3_mem_responder.sv - randomized bench for lc3_mem_responder against an episode-level model
module tb_lc3_mem_responder;

  localparam int RD_LAT   = 2;
  localparam int WR_PULSE = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Mem_OE = 1'b0;
  logic        Mem_WE = 1'b0;
  logic [15:0] MAR = 16'd0;
  logic [15:0] MDR_out = 16'd0;
  logic [15:0] Switches = 16'd0;
  logic [15:0] SRAM_DQ_in;
  logic [15:0] Data_to_CPU, HEX_Data, SRAM_DQ_out;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_DQ_oe, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N, Busy;

  lc3_mem_responder #(.RD_LAT(RD_LAT), .WR_PULSE(WR_PULSE), .IO_ADDR(16'hFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .MAR(MAR),
    .MDR_out(MDR_out), .Switches(Switches), .SRAM_DQ_in(SRAM_DQ_in),
    .Data_to_CPU(Data_to_CPU), .HEX_Data(HEX_Data), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_DQ_out(SRAM_DQ_out), .SRAM_DQ_oe(SRAM_DQ_oe), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Pin-level SRAM and activity counters
  logic [15:0] sram    [0:65535];
  logic [15:0] ref_mem [0:65535];
  bit  sram_loaded = 1'b0;
  int  oe_lo = 0, we_lo = 0, dq_hi = 0, ce_lo = 0, oe_fall = 0, we_fall = 0;
  int  overlap = 0, be_mis = 0;
  logic prev_oe = 1'b1, prev_we = 1'b1;

  function automatic logic [15:0] init_word(input int i);
    if (i == 16'h0010) return 16'hABCD;
    if (i == 16'h0030) return 16'h5555;
    return 16'(i ^ 16'h5A5A);
  endfunction

  assign SRAM_DQ_in = (!SRAM_CE_N && !SRAM_OE_N) ? sram[SRAM_ADDR[15:0]] : 16'hDEAD;

  always @(negedge Clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < 65536; i++) sram[i] = init_word(i);
      sram_loaded = 1'b1;
    end
    if (!SRAM_OE_N) oe_lo++;
    if (!SRAM_WE_N) we_lo++;
    if (SRAM_DQ_oe) dq_hi++;
    if (!SRAM_CE_N) ce_lo++;
    if (!SRAM_OE_N && prev_oe) oe_fall++;
    if (!SRAM_WE_N && prev_we) we_fall++;
    if (!SRAM_OE_N && !SRAM_WE_N) overlap++;
    if (SRAM_UB_N != SRAM_CE_N || SRAM_LB_N != SRAM_CE_N) be_mis++;
    if (!SRAM_CE_N && !SRAM_WE_N && SRAM_DQ_oe) sram[SRAM_ADDR[15:0]] = SRAM_DQ_out;
    prev_oe = SRAM_OE_N;
    prev_we = SRAM_WE_N;
  end

  int n_cmp = 0, n_bad = 0;
  logic [15:0] m_data = 16'd0;
  logic [15:0] m_hex  = 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe episode held for len cycles; entered and left #1 after a rising edge
  task automatic episode(input bit wr, input logic [15:0] a, input logic [15:0] d, input int len);
    bit io = (a == 16'hFFFF);
    bit rd_done = !wr && (io || len >= RD_LAT + 1);
    logic [15:0] exp_rd = io ? Switches : ref_mem[a];
    int o0 = oe_lo, w0 = we_lo, q0 = dq_hi, c0 = ce_lo, of0 = oe_fall, wf0 = we_fall;
    int k;
    int rd_cyc = (len < RD_LAT) ? len : RD_LAT;
    Mem_OE = 1'b1; Mem_WE = wr; MAR = a; MDR_out = d;
    for (int i = 1; i <= len; i++) begin
      @(posedge Clk); #1;
      if (i == 1 && !io) chk("sram_addr", SRAM_ADDR, {4'b0, a});
      if (i == 1 && wr && !io) chk("dq_out", SRAM_DQ_out, d);
      if (i == RD_LAT + 1 && !wr && !io) chk("rd_latency", Data_to_CPU, exp_rd);
      if (i == len && len >= 5) chk("busy_hold", Busy, 1);
    end
    Mem_OE = 1'b0; Mem_WE = 1'b0;
    for (k = 0; k < 30; k++) begin
      @(posedge Clk); #1;
      if (!Busy) break;
    end
    if (k == 30) chk("busy_timeout", 1, 0);
    else if (!(wr && !io && len < 4)) chk("release", k, 0);
    if (wr) begin
      if (io) m_hex = d; else ref_mem[a] = d;
    end else if (rd_done) m_data = exp_rd;
    chk("data", Data_to_CPU, m_data);
    chk("hex", HEX_Data, m_hex);
    chk("oe_cycles", oe_lo - o0, (io || wr) ? 0 : rd_cyc);
    chk("oe_pulses", oe_fall - of0, (io || wr) ? 0 : 1);
    chk("we_cycles", we_lo - w0, (wr && !io) ? WR_PULSE : 0);
    chk("we_pulses", we_fall - wf0, (wr && !io) ? 1 : 0);
    chk("dq_oe_cycles", dq_hi - q0, (wr && !io) ? WR_PULSE + 1 : 0);
    chk("ce_cycles", ce_lo - c0, io ? 0 : (wr ? WR_PULSE + 1 : rd_cyc));
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_ce_n", SRAM_CE_N, 1);
    chk("rst_oe_n", SRAM_OE_N, 1);
    chk("rst_we_n", SRAM_WE_N, 1);
    chk("rst_dq_oe", SRAM_DQ_oe, 0);
    chk("rst_data", Data_to_CPU, 0);
    chk("rst_hex", HEX_Data, 0);
    chk("rst_addr", SRAM_ADDR, 0);
    chk("rst_dq_out", SRAM_DQ_out, 0);
    chk("rst_busy", Busy, 0);
    Reset = 1'b0;

    episode(0, 16'h0010, 16'h0000, 4);
    episode(1, 16'h0020, 16'h1234, 4);
    episode(0, 16'h0020, 16'h0000, 4);
    Switches = 16'h00F0;
    episode(0, 16'hFFFF, 16'h0000, 4);
    episode(1, 16'hFFFF, 16'hBEEF, 4);
    episode(0, 16'h0010, 16'h0000, 8);
    episode(1, 16'h0021, 16'h4321, 8);
    episode(0, 16'h0021, 16'h0000, 4);
    episode(0, 16'h0030, 16'h0000, 4);
    episode(0, 16'h0040, 16'h0000, 1);
    episode(1, 16'h0022, 16'h9999, 1);
    episode(0, 16'h0022, 16'h0000, 4);

    for (int n = 0; n < 40; n++) begin
      bit wr = 1'($urandom_range(0, 1));
      logic [15:0] a = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom_range(0, 63));
      Switches = 16'($urandom);
      episode(wr, a, 16'($urandom), $urandom_range(1, 8));
      repeat ($urandom_range(0, 2)) @(posedge Clk);
      #0;
    end

    // Reset in the middle of a write pulse
    w0 = we_lo;
    Mem_OE = 1'b1; Mem_WE = 1'b1; MAR = 16'hF000; MDR_out = 16'h7777;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk("pre_rst_we_n", SRAM_WE_N, 0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
    m_hex = 16'd0; m_data = 16'd0;
    chk("mid_rst_we_n", SRAM_WE_N, 1);
    chk("mid_rst_dq_oe", SRAM_DQ_oe, 0);
    chk("mid_rst_ce_n", SRAM_CE_N, 1);
    chk("mid_rst_hex", HEX_Data, m_hex);
    chk("mid_rst_busy", Busy, 0);
    repeat (3) @(posedge Clk);
    #1;
    chk("mid_rst_we_total", we_lo - w0, 1);
    episode(0, 16'h0010, 16'h0000, 4);

    chk("oe_we_overlap", overlap, 0);
    chk("ub_lb_follow_ce", be_mis, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
